// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/done handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (magnitude core, sign fix-up in FIN).
module seq_restoring_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] dvsr;
   logic [WIDTH-1:0] dvnd;
   logic [WIDTH-1:0] magA;
   logic [WIDTH-1:0] magB;
   logic [WIDTH-1:0] finQ;
   logic [WIDTH-1:0] finR;
   logic [WIDTH:0]   pShift;
   logic [WIDTH:0]   trial;

   // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value and the trial difference.
   assign pShift = {p, q[WIDTH-1]};
   assign trial  = pShift - {1'b0, dvsr};

`ifdef DIVIDER_SIGNED_EN
   logic negQ;
   logic negR;

   assign magA = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
   assign magB = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
   assign finQ = negQ ? (~q + 1'b1) : q;
   assign finR = negR ? (~p + 1'b1) : p;

   always_ff @(posedge clk) begin
      if (rst) begin
         negQ <= 1'b0;
         negR <= 1'b0;
      end else if (state == IDLE && start && !done) begin
         negQ <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         negR <= dividend[WIDTH-1];
      end
   end
`else
   assign magA = dividend;
   assign magB = divisor;
   assign finQ = q;
   assign finR = p;
`endif

   // Start is refused while done is still high so the result cycle never doubles as an accept cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         cnt         <= '0;
         p           <= '0;
         q           <= '0;
         dvsr        <= '0;
         dvnd        <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start && !done) begin
                  busy        <= 1'b1;
                  div_by_zero <= 1'b0;
                  dvnd        <= dividend;
                  dvsr        <= magB;
                  p           <= '0;
                  q           <= magA;
                  cnt         <= CW'(WIDTH);
                  state       <= (divisor == '0) ? FIN : RUN;
               end
            end
            RUN: begin
               if (!trial[WIDTH]) begin
                  p <= trial[WIDTH-1:0];
               end else begin
                  p <= pShift[WIDTH-1:0];
               end
               q   <= {q[WIDTH-2:0], ~trial[WIDTH]};
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= FIN;
               end
            end
            FIN: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
               if (dvsr == '0) begin
                  quotient    <= '1;
                  remainder   <= dvnd;
                  div_by_zero <= 1'b1;
               end else begin
                  quotient  <= finQ;
                  remainder <= finR;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
